// File: rtl/reg_bank_arbiter_if.sv
// Bus bundle between two requesters (A, B) and reg_bank_arbiter.
//
// Handshake: a requester raises its req bit with wr/addr/wdata valid and
// holds them stable until its gnt bit is seen. gnt stays high for the whole
// transaction. ack is a one-cycle completion pulse (rdata is valid while ack
// is high). The requester drops req in the cycle after ack; a req bit that is
// still high when the arbiter is idle counts as a new request.
// fsm_state mirrors the arbiter state (0 IDLE, 1 GRANT, 2 ACCESS, 3 DONE).
interface reg_bank_arbiter_if #(
   parameter int DATA_W   = 4,
   parameter int NUM_REGS = 4,
   parameter int ADDR_W   = 2
);
   logic [1:0]                 req;
   logic                       wr_a;
   logic [ADDR_W-1:0]          addr_a;
   logic [DATA_W-1:0]          wdata_a;
   logic                       wr_b;
   logic [ADDR_W-1:0]          addr_b;
   logic [DATA_W-1:0]          wdata_b;
   logic [1:0]                 gnt;
   logic [1:0]                 ack;
   logic [DATA_W-1:0]          rdata;
   logic [NUM_REGS*DATA_W-1:0] q_all;
   logic [1:0]                 fsm_state;

   modport master (
      output req, wr_a, addr_a, wdata_a, wr_b, addr_b, wdata_b,
      input  gnt, ack, rdata, q_all, fsm_state
   );

   modport slave (
      input  req, wr_a, addr_a, wdata_a, wr_b, addr_b, wdata_b,
      output gnt, ack, rdata, q_all, fsm_state
   );
endinterface

// File: rtl/reg_bank_arbiter.sv
// reg_bank_arbiter: two-requester arbiter and sequencer for a small bank of
// DATA_W-bit registers. Each transaction runs IDLE -> GRANT -> ACCESS -> DONE.
// Contention (req == 2'b11) is resolved round-robin on the last-served
// requester; define REG_ARB_FIXED_PRIO_EN to make A always win instead.
// Addresses >= NUM_REGS ignore writes and read back 0.
module reg_bank_arbiter #(
   parameter int DATA_W   = 4,
   parameter int NUM_REGS = 4,
   parameter int ADDR_W   = 2
) (
   input logic               sys_clk,
   input logic               sys_rst_n,
   reg_bank_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GRANT  = 2'd1,
      ACCESS = 2'd2,
      DONE   = 2'd3
   } state_t;

   state_t                     state_q, state_d;
   logic [1:0]                 gnt_q, gnt_d;
   logic [1:0]                 ack_q, ack_d;
   logic                       pick_a;
   logic                       cap_en;
   logic                       acc_en;
   logic                       cap_wr;
   logic [ADDR_W-1:0]          cap_addr;
   logic [DATA_W-1:0]          cap_wdata;
   logic [DATA_W-1:0]          rdata_q;
   logic [DATA_W-1:0]          rd_val;
   logic [NUM_REGS*DATA_W-1:0] regs_q;

`ifdef REG_ARB_FIXED_PRIO_EN
   // A wins whenever it requests; no fairness pointer is kept
   always_comb pick_a = bus.req[0];
`else
   logic last_b_q;  // 1 = B was served last, so A wins the next contention

   // Round-robin: on contention serve the requester not served last
   always_comb pick_a = bus.req[0] & (~bus.req[1] | last_b_q);

   // Remember who was selected each time a transaction starts
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         last_b_q <= 1'b1;
      end else if (state_q == IDLE && bus.req != 2'b00) begin
         last_b_q <= ~pick_a;
      end
   end
`endif

   // State register and registered handshake outputs
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q <= IDLE;
         gnt_q   <= 2'b00;
         ack_q   <= 2'b00;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         ack_q   <= ack_d;
      end
   end

   // Next state, next grant/ack and datapath strobes
   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      ack_d   = 2'b00;
      cap_en  = 1'b0;
      acc_en  = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.req != 2'b00) begin
               state_d = GRANT;
               gnt_d   = pick_a ? 2'b01 : 2'b10;
            end
         end
         GRANT: begin
            cap_en  = 1'b1;
            state_d = ACCESS;
         end
         ACCESS: begin
            acc_en  = 1'b1;
            ack_d   = gnt_q;
            state_d = DONE;
         end
         DONE: begin
            gnt_d   = 2'b00;
            state_d = IDLE;
         end
         default: begin
            gnt_d   = 2'b00;
            state_d = IDLE;
         end
      endcase
   end

   // Capture the granted requester's command while in GRANT
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         cap_wr    <= 1'b0;
         cap_addr  <= '0;
         cap_wdata <= '0;
      end else if (cap_en) begin
         cap_wr    <= gnt_q[1] ? bus.wr_b    : bus.wr_a;
         cap_addr  <= gnt_q[1] ? bus.addr_b  : bus.addr_a;
         cap_wdata <= gnt_q[1] ? bus.wdata_b : bus.wdata_a;
      end
   end

   // Read mux; an address with no register behind it yields 0
   always_comb begin
      rd_val = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (cap_addr == i[ADDR_W-1:0]) begin
            rd_val = regs_q[i*DATA_W +: DATA_W];
         end
      end
   end

   // Register bank write and read-data latch during ACCESS
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         regs_q  <= '0;
         rdata_q <= '0;
      end else if (acc_en) begin
         if (cap_wr) begin
            for (int i = 0; i < NUM_REGS; i++) begin
               if (cap_addr == i[ADDR_W-1:0]) begin
                  regs_q[i*DATA_W +: DATA_W] <= cap_wdata;
               end
            end
         end else begin
            rdata_q <= rd_val;
         end
      end
   end

   assign bus.gnt       = gnt_q;
   assign bus.ack       = ack_q;
   assign bus.rdata     = rdata_q;
   assign bus.q_all     = regs_q;
   assign bus.fsm_state = state_q;

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Self-checking bench for reg_bank_arbiter: a main 4-register instance plus a
// 3-register instance for out-of-range addresses. Expected responses come
// from a transaction-level model (register array, last-served flag) and are
// queued; monitors pop and compare on every ack.
module tb_reg_bank_arbiter;

   localparam int DW = 4;
   localparam int NR = 4;
   localparam int AW = 2;
   localparam int NR3 = 3;

   logic clk;
   logic rst_n;

   reg_bank_arbiter_if #(.DATA_W(DW), .NUM_REGS(NR),  .ADDR_W(AW)) bus  ();
   reg_bank_arbiter_if #(.DATA_W(DW), .NUM_REGS(NR3), .ADDR_W(AW)) bus3 ();

   reg_bank_arbiter #(.DATA_W(DW), .NUM_REGS(NR), .ADDR_W(AW)) dut (
      .sys_clk   (clk),
      .sys_rst_n (rst_n),
      .bus       (bus)
   );

   reg_bank_arbiter #(.DATA_W(DW), .NUM_REGS(NR3), .ADDR_W(AW)) dut3 (
      .sys_clk   (clk),
      .sys_rst_n (rst_n),
      .bus       (bus3)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard ----------------
   int n_cmp  = 0;
   int n_fail = 0;
   logic [23:0] exp_q[$];   // {gnt, ack, rdata, q_all} for the main instance
   logic [19:0] exp3_q[$];  // same layout for the 3-register instance

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   logic [DW-1:0] m_regs [NR];
   logic [DW-1:0] m_rdata;
   bit            m_last_b;
   logic [DW-1:0] m3_regs [NR3];
   logic [DW-1:0] m3_rdata;

   bit            c_wr   [2];
   logic [AW-1:0] c_addr [2];
   logic [DW-1:0] c_data [2];

   function automatic void model_reset();
      for (int i = 0; i < NR; i++) m_regs[i] = '0;
      for (int i = 0; i < NR3; i++) m3_regs[i] = '0;
      m_rdata  = '0;
      m3_rdata = '0;
      m_last_b = 1'b1;
   endfunction

   function automatic logic [15:0] q_pack();
      logic [15:0] q;
      for (int i = 0; i < NR; i++) q[i*DW +: DW] = m_regs[i];
      return q;
   endfunction

   function automatic logic [11:0] q3_pack();
      logic [11:0] q;
      for (int i = 0; i < NR3; i++) q[i*DW +: DW] = m3_regs[i];
      return q;
   endfunction

   // Which requester the arbiter serves out of the pending set
   function automatic int model_pick(input logic [1:0] pending);
      int w;
`ifdef REG_ARB_FIXED_PRIO_EN
      w = pending[0] ? 0 : 1;
`else
      if (pending == 2'b11) w = m_last_b ? 0 : 1;
      else                  w = pending[0] ? 0 : 1;
`endif
      m_last_b = (w == 1);
      return w;
   endfunction

   // Perform requester w's command on the model and return the ack response
   function automatic logic [23:0] model_apply(input int w);
      logic [1:0] m;
      int a;
      m = (w == 1) ? 2'b10 : 2'b01;
      a = int'(c_addr[w]);
      if (c_wr[w]) begin
         if (a < NR) m_regs[a] = c_data[w];
      end else begin
         m_rdata = (a < NR) ? m_regs[a] : '0;
      end
      return {m, m, m_rdata, q_pack()};
   endfunction

   // ---------------- monitors ----------------
   always @(negedge clk) begin
      if (rst_n && bus.ack != 2'b00) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_ack", 32'(bus.ack), 32'd0);
         end else begin
            logic [23:0] e;
            e = exp_q.pop_front();
            chk("ack_resp", 32'({bus.gnt, bus.ack, bus.rdata, bus.q_all}), 32'(e));
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n && bus3.ack != 2'b00) begin
         if (exp3_q.size() == 0) begin
            chk("unexpected_ack3", 32'(bus3.ack), 32'd0);
         end else begin
            logic [19:0] e;
            e = exp3_q.pop_front();
            chk("ack_resp3", 32'({bus3.gnt, bus3.ack, bus3.rdata, bus3.q_all}), 32'(e));
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic drive_cmds();
      bus.wr_a    = c_wr[0];
      bus.addr_a  = c_addr[0];
      bus.wdata_a = c_data[0];
      bus.wr_b    = c_wr[1];
      bus.addr_b  = c_addr[1];
      bus.wdata_b = c_data[1];
   endtask

   // Raise req=mask and wait for n acks. hold=1 keeps req high until the
   // last ack; otherwise each requester drops its bit after its own ack.
   task automatic issue(input logic [1:0] mask, input bit hold, input int n);
      logic [1:0] pending;
      int w, got, cyc;
      pending = mask;
      for (int k = 0; k < n; k++) begin
         w = model_pick(pending);
         exp_q.push_back(model_apply(w));
         if (!hold) pending[w] = 1'b0;
      end
      drive_cmds();
      bus.req = mask;
      got = 0;
      cyc = 0;
      while (got < n && cyc < n * 8 + 8) begin
         @(negedge clk);
         cyc++;
         if (bus.ack != 2'b00) begin
            got++;
            if (!hold) bus.req = bus.req & ~bus.ack;
            if (got == n) bus.req = 2'b00;
         end
      end
      chk("ack_count", 32'(got), 32'(n));
      bus.req = 2'b00;
   endtask

   task automatic run3(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] data);
      int a, cyc;
      bit seen;
      a = int'(addr);
      if (wr) begin
         if (a < NR3) m3_regs[a] = data;
      end else begin
         m3_rdata = (a < NR3) ? m3_regs[a] : '0;
      end
      exp3_q.push_back({2'b01, 2'b01, m3_rdata, q3_pack()});
      bus3.wr_a    = wr;
      bus3.addr_a  = addr;
      bus3.wdata_a = data;
      bus3.req     = 2'b01;
      seen = 1'b0;
      cyc  = 0;
      while (!seen && cyc < 16) begin
         @(negedge clk);
         cyc++;
         if (bus3.ack != 2'b00) seen = 1'b1;
      end
      bus3.req = 2'b00;
      chk("ack3_seen", 32'(seen), 32'd1);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      bus.req = 2'b00;
      c_wr[0] = 1'b0; c_addr[0] = '0; c_data[0] = '0;
      c_wr[1] = 1'b0; c_addr[1] = '0; c_data[1] = '0;
      drive_cmds();
      bus3.req = 2'b00; bus3.wr_a = 1'b0; bus3.addr_a = '0; bus3.wdata_a = '0;
      bus3.wr_b = 1'b0; bus3.addr_b = '0; bus3.wdata_b = '0;
      model_reset();

      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_out", 32'({bus.gnt, bus.ack, bus.rdata, bus.fsm_state}), 32'd0);
      chk("reset_q", 32'(bus.q_all), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle_after_reset", 32'({bus.gnt, bus.ack, bus.fsm_state}), 32'd0);

      // A writes 4'hA to addr 2 with cycle-by-cycle latency checks
      c_wr[0] = 1'b1; c_addr[0] = 2'd2; c_data[0] = 4'hA;
      void'(model_pick(2'b01));
      exp_q.push_back(model_apply(0));
      drive_cmds();
      bus.req = 2'b01;
      @(negedge clk);
      chk("lat_c1", 32'({bus.gnt, bus.ack}), 32'(4'b0100));
      @(negedge clk);
      chk("lat_c2", 32'({bus.gnt, bus.ack}), 32'(4'b0100));
      @(negedge clk);
      chk("lat_c3", 32'({bus.gnt, bus.ack}), 32'(4'b0101));
      bus.req = 2'b00;
      @(negedge clk);
      chk("lat_c4", 32'({bus.gnt, bus.ack}), 32'd0);
      chk("q_after_wr", 32'(bus.q_all), 32'(16'h0A00));

      // B reads addr 2
      c_wr[1] = 1'b0; c_addr[1] = 2'd2; c_data[1] = 4'h0;
      issue(2'b10, 1'b0, 1);

      // Held contention: four transactions with req stuck at 11
      c_wr[0] = 1'b1; c_addr[0] = 2'd0; c_data[0] = 4'h3;
      c_wr[1] = 1'b1; c_addr[1] = 2'd1; c_data[1] = 4'h5;
      issue(2'b11, 1'b1, 4);
      @(negedge clk);
      chk("q_after_held", 32'(bus.q_all), 32'(q_pack()));

      // Out-of-range addresses on the 3-register instance
      run3(1'b1, 2'd2, 4'h9);
      run3(1'b0, 2'd2, 4'h0);
      run3(1'b1, 2'd3, 4'h7);
      run3(1'b0, 2'd3, 4'h0);
      @(negedge clk);
      chk("q3_final", 32'(bus3.q_all), 32'(12'h900));

      // A drops req during GRANT; the write still completes
      begin
         int cyc;
         bit seen;
         c_wr[0] = 1'b1; c_addr[0] = 2'd1; c_data[0] = 4'h6;
         void'(model_pick(2'b01));
         exp_q.push_back(model_apply(0));
         drive_cmds();
         bus.req = 2'b01;
         @(negedge clk);
         bus.req = 2'b00;
         seen = 1'b0;
         cyc  = 0;
         while (!seen && cyc < 16) begin
            @(negedge clk);
            cyc++;
            if (bus.ack != 2'b00) seen = 1'b1;
         end
         chk("drop_ack_seen", 32'(seen), 32'd1);
         @(negedge clk);
         chk("drop_q_nibble", 32'(bus.q_all[7:4]), 32'(4'h6));
      end

      // Randomized traffic
      for (int r = 0; r < 60; r++) begin
         logic [1:0] mask;
         mask = 2'($urandom_range(1, 3));
         for (int k = 0; k < 2; k++) begin
            c_wr[k]   = 1'($urandom_range(0, 1));
            c_addr[k] = AW'($urandom_range(0, NR - 1));
            c_data[k] = DW'($urandom_range(0, 15));
         end
         if (mask == 2'b11 && $urandom_range(0, 2) == 0)
            issue(mask, 1'b1, $urandom_range(2, 4));
         else
            issue(mask, 1'b0, (mask == 2'b11) ? 2 : 1);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      @(negedge clk);
      chk("q_after_random", 32'(bus.q_all), 32'(q_pack()));

      // Reset during ACCESS of a write of 4'hF to addr 3
      begin
         int cyc;
         c_wr[0] = 1'b1; c_addr[0] = 2'd3; c_data[0] = 4'hF;
         drive_cmds();
         bus.req = 2'b01;
         cyc = 0;
         while (bus.fsm_state != 2'd2 && cyc < 10) begin
            @(negedge clk);
            cyc++;
         end
         chk("reach_access", 32'(bus.fsm_state), 32'd2);
         rst_n = 1'b1;
         rst_n = 1'b0;
         bus.req = 2'b00;
         #1;
         chk("midrst_out", 32'({bus.gnt, bus.ack, bus.rdata, bus.fsm_state}), 32'd0);
         model_reset();
         repeat (2) @(negedge clk);
         rst_n = 1'b1;
         @(negedge clk);
         chk("midrst_q", 32'(bus.q_all), 32'd0);
         repeat (4) @(negedge clk);
      end

      // Pointer is back at B after reset, so A wins the first contention
      c_wr[0] = 1'b1; c_addr[0] = 2'd2; c_data[0] = 4'hC;
      c_wr[1] = 1'b0; c_addr[1] = 2'd2; c_data[1] = 4'h0;
      issue(2'b11, 1'b0, 2);

      repeat (5) @(negedge clk);
      chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
      chk("exp3_q_drained", 32'(exp3_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
